// File: rtl/daq_acq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : daq_acq_scheduler
// Purpose  : Run-level sequencer: arms the acquisition controller, issues
//            AcqStart triggers (internal period or external edge), counts
//            completed acquisitions and reports run completion.
// Revision : 1.0 - initial release
// ============================================================================
module daq_acq_scheduler #(
    parameter int ARM_DELAY = 64,
    parameter int TRIG_W    = 4,
    parameter int STOP_HOLD = 16
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        StartCmd,
    input  logic        StopCmd,
    input  logic        TrigMode,
    input  logic        ExtTrig,
    input  logic [15:0] TrigPeriod,
    input  logic [15:0] AcqNumber,
    input  logic [15:0] TimeoutCycles,
    input  logic        OnceEnd,
    output logic        ModuleStart,
    output logic        AcqStart,
    output logic        Busy,
    output logic [15:0] AcqDoneCount,
    output logic        AllDone,
    output logic        TimeoutErr
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_TRIG      = 3'd3,
        ST_WAIT_END  = 3'd4,
        ST_GAP       = 3'd5,
        ST_STOP      = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

    localparam logic [15:0] c_ARM_LAST  = 16'(ARM_DELAY - 1);
    localparam logic [15:0] c_TRIG_LAST = 16'(TRIG_W - 1);
    // STOP lasts STOP_HOLD+1 cycles so AllDone lands STOP_HOLD+1 after the fall
    localparam logic [15:0] c_STOP_LAST = 16'(STOP_HOLD);

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_stateCnt;
    logic [15:0] r_toCnt;

    logic        r_cfgMode;
    logic [15:0] r_cfgPeriodLast;
    logic [15:0] r_cfgNumber;
    logic [15:0] r_cfgTimeout;

    logic        r_extMeta;
    logic        r_extSync;
    logic        r_extPrev;
    logic        r_extEdge;
    logic        r_onceQ;
    logic        r_onceD;
    logic        r_stopPending;

    logic        w_startAcc;
    logic        w_onceRise;
    logic        w_stopReq;
    logic        w_countInc;
    logic [15:0] w_newCount;
    logic        w_timeout;
    logic        w_trigEvent;
    logic        w_running;

    assign w_startAcc  = (r_state == ST_IDLE) && StartCmd && !StopCmd;
    assign w_onceRise  = r_onceQ && !r_onceD;
    assign w_stopReq   = r_stopPending || StopCmd;
    assign w_countInc  = (r_state == ST_WAIT_END) && w_onceRise;
    assign w_newCount  = (AcqDoneCount == 16'hFFFF) ? AcqDoneCount : AcqDoneCount + 16'd1;
    assign w_timeout   = (r_state == ST_WAIT_END) && !w_onceRise &&
                         (r_cfgTimeout != 16'd0) && (r_toCnt >= r_cfgTimeout);
    assign w_trigEvent = r_cfgMode ? r_extEdge : (r_stateCnt == r_cfgPeriodLast);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_startAcc) w_nextState = ST_ARM;
            end
            ST_ARM: begin
                if (StopCmd)                        w_nextState = ST_STOP;
                else if (r_stateCnt == c_ARM_LAST)  w_nextState = ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
                if (StopCmd)          w_nextState = ST_STOP;
                else if (w_trigEvent) w_nextState = ST_TRIG;
            end
            ST_TRIG: begin
                if (r_stateCnt == c_TRIG_LAST) w_nextState = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (w_onceRise) begin
                    if (((r_cfgNumber != 16'd0) && (w_newCount == r_cfgNumber)) || w_stopReq)
                        w_nextState = ST_STOP;
                    else
                        w_nextState = ST_GAP;
                end else if (w_timeout) begin
                    w_nextState = ST_STOP;
                end
            end
            ST_GAP: begin
                if (w_stopReq)     w_nextState = ST_STOP;
                else if (!r_onceQ) w_nextState = ST_WAIT_TRIG;
            end
            ST_STOP: begin
                if (r_stateCnt == c_STOP_LAST) w_nextState = ST_DONE;
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    assign w_running = (w_nextState == ST_ARM) || (w_nextState == ST_WAIT_TRIG) ||
                       (w_nextState == ST_TRIG) || (w_nextState == ST_WAIT_END) ||
                       (w_nextState == ST_GAP);

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_stateCnt      <= 16'd0;
            r_toCnt         <= 16'd0;
            r_cfgMode       <= 1'b0;
            r_cfgPeriodLast <= 16'd0;
            r_cfgNumber     <= 16'd0;
            r_cfgTimeout    <= 16'd0;
            r_extMeta       <= 1'b0;
            r_extSync       <= 1'b0;
            r_extPrev       <= 1'b0;
            r_extEdge       <= 1'b0;
            r_onceQ         <= 1'b0;
            r_onceD         <= 1'b0;
            r_stopPending   <= 1'b0;
            ModuleStart     <= 1'b0;
            AcqStart        <= 1'b0;
            Busy            <= 1'b0;
            AllDone         <= 1'b0;
            AcqDoneCount    <= 16'd0;
            TimeoutErr      <= 1'b0;
        end else begin
            r_state <= w_nextState;

            if (w_nextState != r_state) r_stateCnt <= 16'd0;
            else                        r_stateCnt <= r_stateCnt + 16'd1;

            // Timeout window opens on TRIG entry and runs through WAIT_END
            if ((w_nextState == ST_TRIG) && (r_state != ST_TRIG)) r_toCnt <= 16'd0;
            else if (r_toCnt != 16'hFFFF)                          r_toCnt <= r_toCnt + 16'd1;

            if (w_startAcc) begin
                r_cfgMode       <= TrigMode;
                r_cfgPeriodLast <= (TrigPeriod == 16'd0) ? 16'd0 : TrigPeriod - 16'd1;
                r_cfgNumber     <= AcqNumber;
                r_cfgTimeout    <= TimeoutCycles;
            end

            r_extMeta <= ExtTrig;
            r_extSync <= r_extMeta;
            r_extPrev <= r_extSync;
            r_extEdge <= r_extSync && !r_extPrev;
            r_onceQ   <= OnceEnd;
            r_onceD   <= r_onceQ;

            if (r_state == ST_IDLE)
                r_stopPending <= 1'b0;
            else if (StopCmd && ((r_state == ST_TRIG) || (r_state == ST_WAIT_END) ||
                                 (r_state == ST_GAP)))
                r_stopPending <= 1'b1;

            if (w_startAcc)      AcqDoneCount <= 16'd0;
            else if (w_countInc) AcqDoneCount <= w_newCount;

            if (w_startAcc)     TimeoutErr <= 1'b0;
            else if (w_timeout) TimeoutErr <= 1'b1;

            ModuleStart <= w_running;
            AcqStart    <= (w_nextState == ST_TRIG);
            Busy        <= (w_nextState != ST_IDLE);
            AllDone     <= (w_nextState == ST_DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_daq_acq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_daq_acq_scheduler
// Purpose  : Directed bench; expected waveforms are laid out as a timeline
//            from the run-level timing rules and compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_daq_acq_scheduler;

    localparam int ARM_DELAY = 64;
    localparam int TRIG_W    = 4;
    localparam int STOP_HOLD = 16;
    localparam int MAXLEN    = 1024;
    localparam int K_START = 0, K_STOP = 1, K_ONCE = 2, K_EXT = 3, K_RST = 4;

    logic        Clk = 1'b0;
    logic        reset, StartCmd, StopCmd, TrigMode, ExtTrig, OnceEnd;
    logic [15:0] TrigPeriod, AcqNumber, TimeoutCycles;
    logic        ModuleStart, AcqStart, Busy, AllDone, TimeoutErr;
    logic [15:0] AcqDoneCount;

    daq_acq_scheduler #(
        .ARM_DELAY (ARM_DELAY),
        .TRIG_W    (TRIG_W),
        .STOP_HOLD (STOP_HOLD)
    ) dut (
        .Clk           (Clk),
        .reset         (reset),
        .StartCmd      (StartCmd),
        .StopCmd       (StopCmd),
        .TrigMode      (TrigMode),
        .ExtTrig       (ExtTrig),
        .TrigPeriod    (TrigPeriod),
        .AcqNumber     (AcqNumber),
        .TimeoutCycles (TimeoutCycles),
        .OnceEnd       (OnceEnd),
        .ModuleStart   (ModuleStart),
        .AcqStart      (AcqStart),
        .Busy          (Busy),
        .AcqDoneCount  (AcqDoneCount),
        .AllDone       (AllDone),
        .TimeoutErr    (TimeoutErr)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        rst, start, stop, mode, ext, once;
        logic [15:0] period, number, tmo;
    } stim_t;

    typedef struct packed {
        logic        ms, as, busy, ad, to;
        logic [15:0] cnt;
    } exp_t;

    stim_t       stim [MAXLEN];
    exp_t        expv [MAXLEN];
    int          cyc = 0;
    int          base = 0;
    bit          chkEn = 1'b0;
    string       scenName = "";
    int          nChecks = 0;
    int          nFail = 0;
    int          asRises, adPulses;
    logic        prevAs;
    logic [15:0] carryCnt = 16'd0;
    logic        carryTo = 1'b0;
    int          rel;
    exp_t        e;
    int          s, t, fall, ad;
    int          trigAt [4];
    int          riseAt [4];

    always @(posedge Clk) cyc <= cyc + 1;

    // Single compare point: every cycle of a scenario window against the timeline
    always @(negedge Clk) begin
        if (chkEn) begin
            rel = cyc - base;
            e   = expv[rel];
            nChecks++;
            if ({ModuleStart, AcqStart, Busy, AllDone, TimeoutErr, AcqDoneCount} !==
                {e.ms, e.as, e.busy, e.ad, e.to, e.cnt}) begin
                nFail++;
                $display("FAIL %s cycle %0d: got MS=%b AS=%b BUSY=%b AD=%b TO=%b CNT=%0d, want MS=%b AS=%b BUSY=%b AD=%b TO=%b CNT=%0d",
                         scenName, rel, ModuleStart, AcqStart, Busy, AllDone, TimeoutErr, AcqDoneCount,
                         e.ms, e.as, e.busy, e.ad, e.to, e.cnt);
            end
            if (AcqStart && !prevAs) asRises++;
            if (AllDone) adPulses++;
            prevAs = AcqStart;
        end
    end

    task automatic check(input string name, input int got, input int want);
        nChecks++;
        if (got != want) begin
            nFail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic newScenario();
        for (int c = 0; c < MAXLEN; c++) begin
            stim[c]      = '0;
            expv[c].ms   = 1'b0;
            expv[c].as   = 1'b0;
            expv[c].busy = 1'b0;
            expv[c].ad   = 1'b0;
            expv[c].to   = carryTo;
            expv[c].cnt  = carryCnt;
        end
    endtask

    task automatic setCfg(input int from, input logic mode, input int per, input int num, input int tmo);
        for (int c = from; c < MAXLEN; c++) begin
            stim[c].mode   = mode;
            stim[c].period = 16'(per);
            stim[c].number = 16'(num);
            stim[c].tmo    = 16'(tmo);
        end
    endtask

    task automatic stimLevel(input int which, input int from, input int upto);
        for (int c = from; c <= upto; c++) begin
            case (which)
                K_START: stim[c].start = 1'b1;
                K_STOP:  stim[c].stop  = 1'b1;
                K_ONCE:  stim[c].once  = 1'b1;
                K_EXT:   stim[c].ext   = 1'b1;
                default: stim[c].rst   = 1'b1;
            endcase
        end
    endtask

    // Accepted start at cycle st: ModuleStart up until fallC, Busy up to busyEnd, AllDone at adC
    task automatic expRun(input int st, input int fallC, input int busyEnd, input int adC);
        for (int c = st + 1; c < MAXLEN; c++) begin
            expv[c].cnt = 16'd0;
            expv[c].to  = 1'b0;
        end
        for (int c = st + 1; c < fallC; c++)    expv[c].ms   = 1'b1;
        for (int c = st + 1; c <= busyEnd; c++) expv[c].busy = 1'b1;
        if (adC >= 0) expv[adC].ad = 1'b1;
    endtask

    task automatic expTrig(input int tc);
        for (int c = tc; c < tc + TRIG_W; c++) expv[c].as = 1'b1;
    endtask

    task automatic expCount(input int from, input int v);
        for (int c = from; c < MAXLEN; c++) expv[c].cnt = 16'(v);
    endtask

    task automatic expTimeoutErr(input int from);
        for (int c = from; c < MAXLEN; c++) expv[c].to = 1'b1;
    endtask

    task automatic runScenario(input string name, input int len);
        scenName = name;
        asRises  = 0;
        adPulses = 0;
        prevAs   = 1'b0;
        base     = cyc;
        chkEn    = 1'b1;
        for (int c = 0; c < len; c++) begin
            reset         = stim[c].rst;
            StartCmd      = stim[c].start;
            StopCmd       = stim[c].stop;
            TrigMode      = stim[c].mode;
            ExtTrig       = stim[c].ext;
            OnceEnd       = stim[c].once;
            TrigPeriod    = stim[c].period;
            AcqNumber     = stim[c].number;
            TimeoutCycles = stim[c].tmo;
            @(posedge Clk);
            #1;
        end
        chkEn    = 1'b0;
        carryCnt = expv[len].cnt;
        carryTo  = expv[len].to;
    endtask

    initial begin
        reset = 1'b1; StartCmd = 1'b0; StopCmd = 1'b0; TrigMode = 1'b0; ExtTrig = 1'b0;
        OnceEnd = 1'b0; TrigPeriod = 16'd0; AcqNumber = 16'd0; TimeoutCycles = 16'd0;
        repeat (3) @(posedge Clk);
        #1;

        // Internal period 100, three acquisitions, OnceEnd 50 cycles after each trigger
        newScenario();
        s = 2;
        setCfg(0, 1'b0, 100, 3, 0);
        stimLevel(K_START, s, s);
        t = s + 1 + ARM_DELAY + 100;
        for (int k = 0; k < 3; k++) begin
            trigAt[k] = t;
            riseAt[k] = t + 50;
            stimLevel(K_ONCE, riseAt[k], riseAt[k] + 9);
            t = riseAt[k] + 10 + 2 + 100;
        end
        fall = riseAt[2] + 2;
        ad   = fall + STOP_HOLD + 1;
        expRun(s, fall, ad, ad);
        for (int k = 0; k < 3; k++) begin
            expTrig(trigAt[k]);
            expCount(riseAt[k] + 2, k + 1);
        end
        runScenario("internal_n3", ad + 10);
        check("internal_n3 first trigger cycle", trigAt[0], 167);
        check("internal_n3 AcqStart pulses", asRises, 3);
        check("internal_n3 AcqDoneCount", int'(AcqDoneCount), 3);
        check("internal_n3 AllDone pulses", adPulses, 1);
        check("internal_n3 TimeoutErr", int'(TimeoutErr), 0);

        // External trigger: edges in ARM, WAIT_END and GAP are dropped
        newScenario();
        s = 2;
        setCfg(0, 1'b1, 5, 2, 0);
        stimLevel(K_START, s, s);
        stimLevel(K_EXT, 30, 34);
        stimLevel(K_EXT, 100, 105);
        stimLevel(K_EXT, 120, 124);
        stimLevel(K_EXT, 143, 147);
        stimLevel(K_EXT, 170, 175);
        stimLevel(K_ONCE, 140, 149);
        stimLevel(K_ONCE, 200, 209);
        fall = 202;
        ad   = fall + STOP_HOLD + 1;
        expRun(s, fall, ad, ad);
        expTrig(100 + 4);
        expTrig(170 + 4);
        expCount(142, 1);
        expCount(202, 2);
        runScenario("external", ad + 10);
        check("external AcqStart pulses", asRises, 2);
        check("external AcqDoneCount", int'(AcqDoneCount), 2);

        // Readout timeout with TrigPeriod 0 (acts as 1), OnceEnd never arrives
        newScenario();
        s = 2;
        setCfg(0, 1'b0, 0, 0, 200);
        stimLevel(K_START, s, s);
        t    = s + 1 + ARM_DELAY + 1;
        fall = t + 200 + 1;
        ad   = fall + STOP_HOLD + 1;
        expRun(s, fall, ad, ad);
        expTrig(t);
        expTimeoutErr(fall);
        runScenario("timeout", ad + 10);
        check("timeout TimeoutErr", int'(TimeoutErr), 1);
        check("timeout AcqDoneCount", int'(AcqDoneCount), 0);
        check("timeout AllDone pulses", adPulses, 1);
        check("timeout AcqStart pulses", asRises, 1);

        // Stop during WAIT_END with unlimited count: current acquisition finishes
        newScenario();
        s = 2;
        setCfg(0, 1'b0, 20, 0, 0);
        stimLevel(K_START, s, s);
        t = s + 1 + ARM_DELAY + 20;
        stimLevel(K_STOP, 100, 100);
        stimLevel(K_ONCE, 120, 129);
        fall = 122;
        ad   = fall + STOP_HOLD + 1;
        expRun(s, fall, ad, ad);
        expTrig(t);
        expCount(122, 1);
        runScenario("stop_in_wait_end", ad + 30);
        check("stop_in_wait_end AcqStart pulses", asRises, 1);
        check("stop_in_wait_end AcqDoneCount", int'(AcqDoneCount), 1);

        // Start+Stop together does nothing; a second Start during ARM is ignored
        newScenario();
        setCfg(0, 1'b0, 30, 1, 0);
        stimLevel(K_START, 2, 2);
        stimLevel(K_STOP, 2, 2);
        s = 10;
        stimLevel(K_START, s, s);
        stimLevel(K_START, 40, 40);
        setCfg(40, 1'b1, 2, 5, 3);
        t = s + 1 + ARM_DELAY + 30;
        stimLevel(K_ONCE, 130, 139);
        fall = 132;
        ad   = fall + STOP_HOLD + 1;
        expRun(s, fall, ad, ad);
        expTrig(t);
        expCount(132, 1);
        runScenario("start_conflicts", ad + 10);
        check("start_conflicts AcqStart pulses", asRises, 1);
        check("start_conflicts AllDone pulses", adPulses, 1);

        // Reset asserted while AcqStart is high on the second trigger
        newScenario();
        s = 2;
        setCfg(0, 1'b0, 10, 0, 0);
        stimLevel(K_START, s, s);
        stimLevel(K_ONCE, 90, 94);
        stimLevel(K_RST, 108, 108);
        expRun(s, 109, 108, -1);
        expTrig(77);
        for (int c = 107; c <= 108; c++) expv[c].as = 1'b1;
        expCount(92, 1);
        expCount(109, 0);
        runScenario("reset_in_trig", 150);
        check("reset_in_trig AllDone pulses", adPulses, 0);
        check("reset_in_trig Busy", int'(Busy), 0);
        check("reset_in_trig AcqStart pulses", asRises, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
